// File: rtl/vending_pkg.sv
// Shared types, coin encodings and amount helpers for the vending machine sequencer.
package vending_pkg;

    localparam int unsigned AMT_W     = 5;
    localparam int unsigned COIN_UNIT = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CALC,
        S_WAIT,
        S_PAYOUT,
        S_FINISH
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    localparam logic [AMT_W-1:0] VAL_5  = 5'd5;
    localparam logic [AMT_W-1:0] VAL_10 = 5'd10;
    localparam logic [AMT_W-1:0] VAL_20 = 5'd20;

    function automatic logic [AMT_W-1:0] coin_to_amt(input logic [1:0] code);
        logic [AMT_W-1:0] amt;
        case (code)
            COIN_5:  amt = VAL_5;
            COIN_10: amt = VAL_10;
            COIN_20: amt = VAL_20;
            default: amt = '0;
        endcase
        return amt;
    endfunction

    function automatic logic [AMT_W-1:0] floor_unit(input logic [AMT_W-1:0] v);
        return AMT_W'((int'(v) / COIN_UNIT) * COIN_UNIT);
    endfunction

endpackage

// File: rtl/payout_pulser.sv
// Turns a loaded amount into one pulse per coin unit, with a gap cycle after every pulse.
module payout_pulser
    import vending_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [AMT_W-1:0] load_value,
    input  logic             run,
    output logic             pulse,
    output logic             empty
);

    logic [AMT_W-1:0] rem_q, rem_d;
    logic             pulse_q, pulse_d;

    // pulse_q doubles as the phase bit: a high pulse is always followed by a gap
    always_comb begin
        rem_d   = rem_q;
        pulse_d = 1'b0;
        if (load) begin
            rem_d = floor_unit(load_value);
        end else if (run && !pulse_q && rem_q != '0) begin
            pulse_d = 1'b1;
            rem_d   = rem_q - AMT_W'(COIN_UNIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign empty = (rem_q == '0) && !pulse_q;

endmodule

// File: rtl/vending_ctrl.sv
// Vending sequencer: coin accumulation, price check, change-calculator handshake and
// coin-return pulsing for both change and cancel/timeout refunds.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned PRICE0         = 15,
    parameter int unsigned PRICE1         = 20,
    parameter int unsigned PRICE2         = 25,
    parameter int unsigned PRICE3         = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [1:0]       coin_value,
    input  logic             sel_valid,
    input  logic [1:0]       sel_id,
    input  logic             cancel,
    input  logic             calc_done,
    input  logic [AMT_W-1:0] change_in,
    output logic [AMT_W-1:0] current_amount_display,
    output logic [AMT_W-1:0] product_price,
    output logic             change_calculator_en,
    output logic             timeout_flag,
    output logic             coin_reject,
    output logic             insufficient,
    output logic             vend,
    output logic             change_pulse,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] amount_q, amount_d;
    logic [AMT_W-1:0] price_q, price_d;
    logic             refund_q, refund_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             calc_en_q, calc_en_d;
    logic             tflag_q, tflag_d;
    logic             reject_q, reject_d;
    logic             insuff_q, insuff_d;
    logic             vend_q, vend_d;
    logic             busy_q, busy_d;

    logic             pay_load;
    logic [AMT_W-1:0] pay_value;
    logic             pay_empty;
    logic             pay_pulse;

    logic [AMT_W-1:0] sel_price;
    logic [AMT_W:0]   coin_sum;
    logic             coin_clean;
    logic             coin_accept;
    logic             timed_out;

    always_comb begin
        case (sel_id)
            2'd0:    sel_price = AMT_W'(PRICE0);
            2'd1:    sel_price = AMT_W'(PRICE1);
            2'd2:    sel_price = AMT_W'(PRICE2);
            default: sel_price = AMT_W'(PRICE3);
        endcase
    end

    assign coin_sum   = {1'b0, amount_q} + {1'b0, coin_to_amt(coin_value)};
    assign coin_clean = coin_valid && (coin_value != COIN_NONE) && !coin_sum[AMT_W]
                        && !cancel && !sel_valid;
    // Firing one count early means the refund edge is the one where the count reaches the limit
    assign timed_out  = (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        amount_d    = amount_q;
        price_d     = price_q;
        refund_d    = refund_q;
        idle_cnt_d  = idle_cnt_q;
        calc_en_d   = 1'b0;
        tflag_d     = 1'b0;
        insuff_d    = 1'b0;
        vend_d      = 1'b0;
        pay_load    = 1'b0;
        pay_value   = '0;
        coin_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_clean) begin
                    coin_accept = 1'b1;
                    amount_d    = coin_sum[AMT_W-1:0];
                    idle_cnt_d  = '0;
                    state_d     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel || timed_out) begin
                    pay_load   = 1'b1;
                    pay_value  = amount_q;
                    refund_d   = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = S_PAYOUT;
                end else if (sel_valid) begin
                    idle_cnt_d = '0;
                    if (amount_q >= sel_price) begin
                        price_d   = sel_price;
                        calc_en_d = 1'b1;
                        state_d   = S_CALC;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end else if (coin_clean) begin
                    coin_accept = 1'b1;
                    amount_d    = coin_sum[AMT_W-1:0];
                    idle_cnt_d  = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            S_CALC: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (calc_done) begin
                    pay_load  = 1'b1;
                    pay_value = change_in;
                    vend_d    = 1'b1;
                    state_d   = S_PAYOUT;
                end
            end
            S_PAYOUT: begin
                if (pay_empty) begin
                    tflag_d = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                amount_d = '0;
                price_d  = '0;
                refund_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        reject_d = coin_valid && !coin_accept;
        busy_d   = state_d inside {S_CALC, S_WAIT, S_PAYOUT, S_FINISH};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            amount_q   <= '0;
            price_q    <= '0;
            refund_q   <= 1'b0;
            idle_cnt_q <= '0;
            calc_en_q  <= 1'b0;
            tflag_q    <= 1'b0;
            reject_q   <= 1'b0;
            insuff_q   <= 1'b0;
            vend_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            amount_q   <= amount_d;
            price_q    <= price_d;
            refund_q   <= refund_d;
            idle_cnt_q <= idle_cnt_d;
            calc_en_q  <= calc_en_d;
            tflag_q    <= tflag_d;
            reject_q   <= reject_d;
            insuff_q   <= insuff_d;
            vend_q     <= vend_d;
            busy_q     <= busy_d;
        end
    end

    payout_pulser u_payout (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pay_load),
        .load_value (pay_value),
        .run        (state_q == S_PAYOUT),
        .pulse      (pay_pulse),
        .empty      (pay_empty)
    );

    assign current_amount_display = amount_q;
    assign product_price          = price_q;
    assign change_calculator_en   = calc_en_q;
    assign timeout_flag           = tflag_q;
    assign coin_reject            = reject_q;
    assign insufficient           = insuff_q;
    assign vend                   = vend_q;
    assign change_pulse           = pay_pulse;
    assign busy                   = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: purchases, zero change, refunds, rejects, timeout, reset.
module tb_vending_ctrl;
    import vending_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_value = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'b00;
    logic       cancel = 1'b0;
    logic       calc_done = 1'b0;
    logic [4:0] change_in = 5'd0;

    logic [4:0] amount;
    logic [4:0] price;
    logic       calc_en;
    logic       tflag;
    logic       reject;
    logic       insuff;
    logic       vend;
    logic       cpulse;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_en = 0, n_vend = 0, n_pulse = 0, n_tflag = 0;

    vending_ctrl #(
        .TIMEOUT_CYCLES (8),
        .PRICE0         (15),
        .PRICE1         (20),
        .PRICE2         (25),
        .PRICE3         (30)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .coin_valid             (coin_valid),
        .coin_value             (coin_value),
        .sel_valid              (sel_valid),
        .sel_id                 (sel_id),
        .cancel                 (cancel),
        .calc_done              (calc_done),
        .change_in              (change_in),
        .current_amount_display (amount),
        .product_price          (price),
        .change_calculator_en   (calc_en),
        .timeout_flag           (tflag),
        .coin_reject            (reject),
        .insufficient           (insuff),
        .vend                   (vend),
        .change_pulse           (cpulse),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (calc_en) n_en++;
        if (vend)    n_vend++;
        if (cpulse)  n_pulse++;
        if (tflag)   n_tflag++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        n_en = 0; n_vend = 0; n_pulse = 0; n_tflag = 0;
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_value = code;
        tick();
        coin_valid = 1'b0;
        coin_value = COIN_NONE;
    endtask

    task automatic select(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Calculator model: done one cycle after the enable cycle, returning chg.
    task automatic do_calc(input string tag, input logic [4:0] chg);
        check({tag, "_en"}, int'(calc_en), 1);
        tick();
        calc_done = 1'b1;
        change_in = chg;
        tick();
        calc_done = 1'b0;
        change_in = 5'd0;
        check({tag, "_vend"}, int'(vend), 1);
    endtask

    initial begin
        // Reset state
        run(2);
        check("rst_amount", int'(amount), 0);
        check("rst_outputs", int'({price, calc_en, tflag, reject, insuff, vend, cpulse, busy}), 0);
        #2 rst_n = 1'b1;
        tick();

        // Purchase with change 10
        clear_counts();
        coin(COIN_10); coin(COIN_10); coin(COIN_5);
        check("t1_amount", int'(amount), 25);
        select(2'd0);
        check("t1_price", int'(price), 15);
        check("t1_busy", int'(busy), 1);
        do_calc("t1", 5'd10);
        run(12);
        check("t1_n_en", n_en, 1);
        check("t1_n_vend", n_vend, 1);
        check("t1_n_pulse", n_pulse, 2);
        check("t1_n_tflag", n_tflag, 1);
        check("t1_amount_end", int'(amount), 0);
        check("t1_busy_end", int'(busy), 0);

        // Exact payment, zero change: FINISH right after the single PAYOUT cycle
        clear_counts();
        coin(COIN_10); coin(COIN_10);
        select(2'd1);
        do_calc("t2", 5'd0);
        tick();
        check("t2_tflag_next", int'(tflag), 1);
        tick();
        check("t2_idle", int'(busy), 0);
        check("t2_amount", int'(amount), 0);
        check("t2_n_pulse", n_pulse, 0);
        check("t2_n_vend", n_vend, 1);

        // Cancel refund of 15
        clear_counts();
        coin(COIN_5); coin(COIN_10);
        do_cancel();
        check("t3_busy", int'(busy), 1);
        run(12);
        check("t3_n_pulse", n_pulse, 3);
        check("t3_n_vend", n_vend, 0);
        check("t3_n_en", n_en, 0);
        check("t3_n_tflag", n_tflag, 1);

        // Insufficient credit stays in COLLECT; the cancel then refunds 10
        clear_counts();
        coin(COIN_10);
        select(2'd2);
        check("t3_insuff", int'(insuff), 1);
        check("t3_ins_amount", int'(amount), 10);
        check("t3_ins_busy", int'(busy), 0);
        do_cancel();
        run(10);
        check("t3_ins_refund", n_pulse, 2);
        check("t3_ins_en", n_en, 0);

        // Overflow and invalid-code rejection, then coin+selection collision
        clear_counts();
        coin(COIN_20); coin(COIN_5);
        check("t4_amount", int'(amount), 25);
        coin(COIN_10);
        check("t4_ovf_reject", int'(reject), 1);
        check("t4_ovf_amount", int'(amount), 25);
        coin(COIN_NONE);
        check("t4_code0_reject", int'(reject), 1);
        check("t4_code0_amount", int'(amount), 25);
        coin_valid = 1'b1; coin_value = COIN_5;
        sel_valid  = 1'b1; sel_id     = 2'd2;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        check("t4_col_reject", int'(reject), 1);
        check("t4_col_amount", int'(amount), 25);
        check("t4_col_price", int'(price), 25);
        do_calc("t4", 5'd7);
        run(10);
        check("t4_round_pulse", n_pulse, 1);
        check("t4_n_tflag", n_tflag, 1);

        // Inactivity refund after 8 idle cycles
        clear_counts();
        coin(COIN_5);
        run(7);
        check("t5_before_to", int'(busy), 0);
        tick();
        check("t5_at_to", int'(busy), 1);
        run(8);
        check("t5_n_pulse", n_pulse, 1);
        check("t5_n_vend", n_vend, 0);
        check("t5_n_tflag", n_tflag, 1);

        // Reset during the second pulse of a 15-unit refund
        coin(COIN_5); coin(COIN_10);
        do_cancel();
        run(3);
        check("t6_second_pulse", int'(cpulse), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_pulse", int'(cpulse), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_amount", int'(amount), 0);
        #2 rst_n = 1'b1;
        tick();
        clear_counts();
        coin(COIN_10);
        check("t6_new_amount", int'(amount), 10);
        check("t6_new_reject", int'(reject), 0);
        run(4);
        check("t6_no_pulses", n_pulse, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Top-level sequencer for the vending machine datapath. Accumulates inserted coins and resolves a product selection against a per-slot price table. Drives the change calculator (enable, amount, price, clear) and turns the returned change into coin-return pulses, refunding on cancel or inactivity. Sits between the coin/keypad front end and `change_calculator`, whose ports it connects to one-for-one.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000: idle cycles in COLLECT before automatic refund (≥2).
- `PRICE0`..`PRICE3`, 15 / 20 / 25 / 30: slot prices; each must be a multiple of 5 and ≤31.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `coin_valid` in 1: one-cycle coin strobe.
- `coin_value` in 2: 01=5, 10=10, 11=20, 00=invalid (rejected).
- `sel_valid` in 1: one-cycle selection strobe.
- `sel_id` in 2: product slot.
- `cancel` in 1: one-cycle refund request.
- `calc_done` in 1: from `change_calculator_done`.
- `change_in` in 5: from `change_out`.
- `current_amount_display` out 5: accumulated credit, to calculator and display.
- `product_price` out 5: latched price of accepted selection.
- `change_calculator_en` out 1: one-cycle start pulse.
- `timeout_flag` out 1: one-cycle calculator clear.
- `coin_reject` out 1: one-cycle pulse; coin returned unaccepted.
- `insufficient` out 1: one-cycle pulse; selection refused.
- `vend` out 1: one-cycle product release pulse.
- `change_pulse` out 1: one pulse per 5 units returned.
- `busy` out 1: high in CALC, WAIT, PAYOUT, FINISH.

## Operation
- States: IDLE, COLLECT, CALC, WAIT, PAYOUT, FINISH.
- IDLE: amount 0. A valid coin adds its value and moves to COLLECT. `sel_valid` and `cancel` are ignored.
- COLLECT, priority cancel > selection > coin:
  - `cancel`, or idle counter reaching `TIMEOUT_CYCLES`: remaining ← amount, refund=1, go to PAYOUT. No `vend`, no `change_calculator_en`.
  - `sel_valid` with amount ≥ PRICE[sel_id]: latch price, go to CALC.
  - `sel_valid` with amount < PRICE[sel_id]: pulse `insufficient`, stay in COLLECT, counter cleared.
  - Accepted coin: adds value and clears the counter.
- Coin rejection: a coin is rejected with `coin_reject` if any of these hold; amount is unchanged.
  - It would push amount past 31.
  - It carries code 00.
  - It arrives with `cancel` or `sel_valid` in the same cycle.
  - It arrives in any state other than IDLE or COLLECT.
- CALC: `change_calculator_en` = 1 for exactly one cycle, then WAIT.
- WAIT: on `calc_done`, remaining ← `change_in`, pulse `vend`, go to PAYOUT. A value of `change_in` that is not a multiple of 5 is rounded down to a multiple of 5.
- PAYOUT, in a pulse/gap cycle pair:
  - While remaining ≠ 0: `change_pulse` high one cycle, low the next, remaining −= 5.
  - When remaining = 0: go to FINISH.
- FINISH: `timeout_flag` = 1 for one cycle; amount, price and refund cleared; go to IDLE.
- Arithmetic: 5-bit unsigned throughout. Overflow is prevented by coin rejection; remaining never underflows.
- Reset (any time, including mid-payout): state IDLE, all registers 0, all outputs 0. Undispensed change is discarded.

## Timing
- Inputs are sampled on the edge; outputs are registered.
- Coin accepted at edge k: `current_amount_display` updated after edge k.
- Selection accepted at edge k: `change_calculator_en` high in cycle k+1.
- `calc_done` sampled at edge m: `vend` high in cycle m+1, first `change_pulse` in cycle m+2.
- Change C: C/5 pulses on alternate cycles, then `timeout_flag` in the cycle after the last gap cycle.
- C = 0: PAYOUT lasts one cycle, then FINISH.
- Timeout: counter increments each COLLECT cycle without an accepted coin, valid selection or insufficient selection. The refund starts on the edge where it equals `TIMEOUT_CYCLES`.

## Structure
- Package `vending_pkg`:
  - state enum;
  - coin code constants and values;
  - `COIN_UNIT` = 5;
  - `AMT_W` = 5.
- Sub-module `payout_pulser`:
  - load value;
  - pulse/gap generator;
  - empty flag;
  - used for both change and refund.
- Idle timer is inline.

## Test plan
- Reset; coins 10, 10, 5; select slot 0 (15); model calculator returns 10 with done one cycle after enable → one `change_calculator_en`, one `vend`, 2 `change_pulse`, one `timeout_flag`, amount 0.
- Coins 10, 10; select slot 1 (20); change 0 → `vend`, zero `change_pulse`, `timeout_flag`, return to IDLE.
- Coins 5, 10; `cancel` → 3 `change_pulse`, no `vend`, no `change_calculator_en`. Also amount 10 with select slot 2 (25) → `insufficient`, state stays COLLECT, amount 10.
- Amount 25, insert 10 → `coin_reject`, amount 25. Coin and `sel_valid` in the same cycle → coin rejected, selection processed.
- `TIMEOUT_CYCLES` = 8, one coin 5, then idle → refund starts 8 cycles later, 1 `change_pulse`.
- `rst_n` low during second `change_pulse` of a 15-unit payout → all outputs 0 immediately, IDLE; next coin accepted normally.
